// File: rtl/single_port_ram_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : single_port_ram_pkg
//  Description : Shared constants for the single-port RAM: default geometry
//                and the wr_rd operation encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package single_port_ram_pkg;

    localparam int c_default_addr_width = 5;
    localparam int c_default_data_width = 32;
    localparam int c_default_mem_depth  = 32;

    // Encoding of the wr_rd select input
    localparam logic OP_WRITE = 1'b1;
    localparam logic OP_READ  = 1'b0;

endpackage
`default_nettype wire

// File: rtl/spram_mem_array.sv
`default_nettype none
// ============================================================================
//  Module      : spram_mem_array
//  Description : Word storage for the single-port RAM. Provides a full clear
//                on reset, a write port and a registered read port. Callers
//                only assert we/re for addresses inside MEM_DEPTH.
//  Revision    : 1.0 - initial release
// ============================================================================
module spram_mem_array #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32,
    parameter int MEM_DEPTH  = 32
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  we,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata
);

    // Index width just wide enough for MEM_DEPTH words; upper address bits
    // are already range-checked by the request decoder.
    localparam int c_idx_w = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

    logic [DATA_WIDTH-1:0] r_mem [0:MEM_DEPTH-1];
    logic [DATA_WIDTH-1:0] r_rdata;
    logic [c_idx_w-1:0]    w_idx;

    assign w_idx = c_idx_w'(addr);
    assign rdata = r_rdata;

    // Reset clears every word and the read register; otherwise write/read.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int i = 0; i < MEM_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_rdata <= '0;
        end else begin
            if (we) begin
                r_mem[w_idx] <= wdata;
            end
            if (re) begin
                r_rdata <= r_mem[w_idx];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/single_port_ram.sv
`default_nettype none
// ============================================================================
//  Module      : single_port_ram
//  Description : Single-port synchronous RAM with valid/ready request
//                handshake, one-cycle read latency and an optional
//                single-cycle error flag for rejected requests.
//                Build option: define SINGLE_PORT_RAM_ERROR_EN to enable
//                error reporting; otherwise error is tied low and invalid
//                requests are silently dropped.
//  Revision    : 1.0 - initial release
// ============================================================================
module single_port_ram
    import single_port_ram_pkg::*;
#(
    parameter int ADDR_WIDTH = c_default_addr_width,
    parameter int DATA_WIDTH = c_default_data_width,
    parameter int MEM_DEPTH  = c_default_mem_depth
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  en,
    input  logic                  wr_rd,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  valid,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  ready,
    output logic                  error
);

    // One extra bit so the comparison also works when MEM_DEPTH == 2**ADDR_WIDTH
    localparam logic [ADDR_WIDTH:0] c_depth_lim = (ADDR_WIDTH + 1)'(MEM_DEPTH);

    logic r_wake;
    logic r_ready;
    logic w_in_range;
    logic w_accept;
    logic w_we;
    logic w_re;

    // Ready comes back two edges after reset release: r_wake marks the first.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_wake  <= 1'b0;
            r_ready <= 1'b0;
        end else begin
            r_wake  <= 1'b1;
            r_ready <= r_wake;
        end
    end

    assign ready      = r_ready;
    assign w_in_range = ({1'b0, addr} < c_depth_lim);
    assign w_accept   = r_ready & valid & en & w_in_range;
    assign w_we       = w_accept & (wr_rd == OP_WRITE);
    assign w_re       = w_accept & (wr_rd == OP_READ);

`ifdef SINGLE_PORT_RAM_ERROR_EN
    logic r_error;

    // Flag a presented request that is disabled or out of range, for one cycle.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_error <= 1'b0;
        end else begin
            r_error <= r_ready & valid & (~en | ~w_in_range);
        end
    end

    assign error = r_error;
`else
    assign error = 1'b0;
`endif

    spram_mem_array #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .MEM_DEPTH  (MEM_DEPTH)
    ) u_mem (
        .clk   (clk),
        .rstn  (rstn),
        .we    (w_we),
        .re    (w_re),
        .addr  (addr),
        .wdata (din),
        .rdata (dout)
    );

endmodule
`default_nettype wire

// File: tb/tb_single_port_ram.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_single_port_ram
//  Description : Self-checking bench for single_port_ram with a behavioural
//                reference model, directed scenarios and random traffic,
//                repeated at two clock periods.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_single_port_ram;

    localparam int AW    = 6;
    localparam int DW    = 32;
    localparam int DEPTH = 32;
`ifdef SINGLE_PORT_RAM_ERROR_EN
    localparam bit c_err_en = 1'b1;
`else
    localparam bit c_err_en = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          en = 1'b0;
    logic          wr_rd = 1'b0;
    logic [AW-1:0] addr = '0;
    logic [DW-1:0] din = '0;
    logic          valid = 1'b0;
    logic [DW-1:0] dout;
    logic          ready;
    logic          error;

    realtime half_period = 5.0;
    always #(half_period) clk = ~clk;

    single_port_ram #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .MEM_DEPTH  (DEPTH)
    ) dut (
        .clk   (clk),
        .rstn  (rstn),
        .en    (en),
        .wr_rd (wr_rd),
        .addr  (addr),
        .din   (din),
        .valid (valid),
        .dout  (dout),
        .ready (ready),
        .error (error)
    );

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: plain array plus a counter of edges since reset
    logic [DW-1:0] model_mem [DEPTH];
    logic [DW-1:0] model_dout = '0;
    bit            model_err = 1'b0;
    bit            model_ready = 1'b0;
    int            edges_since_rst = 0;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cycle(input bit r, input bit e, input bit w, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input bit v, input string tag);
        bit acc;
        rstn  = r;
        en    = e;
        wr_rd = w;
        addr  = a;
        din   = d;
        valid = v;
        @(posedge clk);
        if (!r) begin
            for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
            model_dout      = '0;
            model_err       = 1'b0;
            model_ready     = 1'b0;
            edges_since_rst = 0;
        end else begin
            acc       = model_ready && v && e && (int'(a) < DEPTH);
            model_err = c_err_en && model_ready && v && (!e || int'(a) >= DEPTH);
            if (acc) begin
                if (w) model_mem[a] = d;
                else   model_dout   = model_mem[a];
            end
            edges_since_rst++;
            model_ready = (edges_since_rst >= 2);
        end
        #1;
        chk({tag, "/dout"},  dout,  model_dout);
        chk({tag, "/ready"}, {31'd0, ready}, {31'd0, model_ready});
        chk({tag, "/error"}, {31'd0, error}, {31'd0, model_err});
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input string tag);
        cycle(1'b1, 1'b1, 1'b1, a, d, 1'b1, tag);
    endtask

    task automatic rd(input logic [AW-1:0] a, input string tag);
        cycle(1'b1, 1'b1, 1'b0, a, '0, 1'b1, tag);
    endtask

    task automatic idle(input string tag);
        cycle(1'b1, 1'b1, 1'b0, '0, '0, 1'b0, tag);
    endtask

    task automatic run_suite();
        // Reset and wake-up
        cycle(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, "reset");
        cycle(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, "reset");
        idle("wake1");
        idle("wake2");
        chk("ready_after_reset", {31'd0, ready}, 32'd1);

        // Single write/read
        wr(6'd5, 32'hDEADBEEF, "single_wr");
        rd(6'd5, "single_rd");
        chk("single_rd_value", dout, 32'hDEADBEEF);
        chk("single_rd_error", {31'd0, error}, 32'd0);

        // Back-to-back writes then reads
        for (int i = 0; i < 32; i++) wr(AW'(i), 32'(i) * 32'h01010101, "b2b_wr");
        for (int i = 0; i < 32; i++) begin
            rd(AW'(i), "b2b_rd");
            chk("b2b_value", dout, 32'(i) * 32'h01010101);
        end

        // Reset coincident with a write
        cycle(1'b0, 1'b1, 1'b1, 6'd3, 32'h12345678, 1'b1, "rst_wr");
        idle("rst_wr_wake1");
        chk("rst_wr_ready_low", {31'd0, ready}, 32'd0);
        idle("rst_wr_wake2");
        rd(6'd3, "rst_wr_rd");
        chk("rst_wr_value", dout, 32'd0);

        // Reset coincident with a read
        wr(6'd7, 32'hA5A5A5A5, "rst_rd_wr");
        rd(6'd7, "rst_rd_pre");
        chk("rst_rd_pre_value", dout, 32'hA5A5A5A5);
        cycle(1'b0, 1'b1, 1'b0, 6'd7, '0, 1'b1, "rst_rd");
        chk("rst_rd_dout", dout, 32'd0);
        idle("rst_rd_wake1");
        idle("rst_rd_wake2");
        rd(6'd7, "rst_rd_after");
        chk("rst_rd_cleared", dout, 32'd0);

        // Disabled request
        cycle(1'b1, 1'b0, 1'b1, 6'd9, 32'hFFFFFFFF, 1'b1, "err_en0");
        chk("err_en0_flag", {31'd0, error}, {31'd0, c_err_en});
        idle("err_clear");
        chk("err_clear_flag", {31'd0, error}, 32'd0);
        rd(6'd9, "err_rd");
        chk("err_rd_value", dout, 32'd0);

        // Address boundary
        wr(6'd31, 32'hCAFEF00D, "bound_wr31");
        wr(6'd32, 32'h11111111, "bound_wr32");
        chk("bound_wr32_err", {31'd0, error}, {31'd0, c_err_en});
        rd(6'd40, "bound_rd40");
        rd(6'd31, "bound_rd31");
        chk("bound_rd31_value", dout, 32'hCAFEF00D);
        rd(6'd0, "bound_rd0");
        chk("bound_rd0_value", dout, 32'd0);

        // Random traffic against the model
        for (int n = 0; n < 300; n++) begin
            cycle(($urandom_range(0, 49) != 0), ($urandom_range(0, 9) != 0), 1'($urandom),
                  AW'($urandom_range(0, 40)), $urandom, ($urandom_range(0, 4) != 0), "rand");
        end
    endtask

    initial begin
        half_period = 5.0;
        run_suite();
        half_period = 2.0;
        run_suite();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/single_port_ram.md
SINGLE_PORT_RAM -- requirements
Module: single_port_ram

Interface
- REQ-001 SHALL have parameter ADDR_WIDTH, default 5, address bus width.
- REQ-002 SHALL have parameter DATA_WIDTH, default 32, word width.
- REQ-003 SHALL have parameter MEM_DEPTH, default 32, number of words, at most 2**ADDR_WIDTH.
- REQ-004 SHALL have port clk, input, 1 bit, the single clock; all logic on its rising edge.
- REQ-005 SHALL have port rstn, input, 1 bit, synchronous active-low reset.
- REQ-006 SHALL have port en, input, 1 bit, RAM enable.
- REQ-007 SHALL have port wr_rd, input, 1 bit, operation select: 1 = write, 0 = read.
- REQ-008 SHALL have port addr, input, ADDR_WIDTH bits, word address.
- REQ-009 SHALL have port din, input, DATA_WIDTH bits, write data.
- REQ-010 SHALL have port valid, input, 1 bit, request strobe.
- REQ-011 SHALL have port dout, output, DATA_WIDTH bits, registered read data.
- REQ-012 SHALL have port ready, output, 1 bit, registered; RAM can accept a request.
- REQ-013 SHALL have port error, output, 1 bit, registered single-cycle error flag.

Function
- REQ-014 A request SHALL be accepted on a rising edge where rstn=1, ready=1, valid=1, en=1 and addr<MEM_DEPTH.
- REQ-015 An accepted write SHALL store din at mem[addr] on that edge; dout SHALL be unchanged.
- REQ-016 An accepted read SHALL load mem[addr] into dout on that edge, giving one-cycle latency; dout SHALL hold until the next accepted read or reset.
- REQ-017 A read of an address in the cycle after a write to it SHALL return the newly written data.
- REQ-018 ready SHALL be 1 in every cycle except the reset cycle and the first cycle after rstn deasserts; back-to-back requests every cycle SHALL be accepted.
- REQ-019 When valid=0 or en=0 with valid=0, memory, dout and error SHALL be unchanged; error SHALL return to 0 on the following edge.
- REQ-020 A request with valid=1, en=0 SHALL not be accepted and SHALL set error=1 for the next cycle.
- REQ-021 A request with valid=1, en=1 and addr>=MEM_DEPTH SHALL not be accepted and SHALL set error=1 for the next cycle.
- REQ-022 A rejected request SHALL modify neither memory nor dout.
- REQ-023 The behaviour SHALL be independent of clock frequency; there SHALL be no internal timing assumptions.

Reset
- REQ-024 When rstn=0 at a rising edge, the block SHALL set dout=0, error=0 and ready=0, and SHALL clear all MEM_DEPTH words to 0.
- REQ-025 Reset SHALL take priority over any request in the same cycle; a write or read coincident with reset SHALL be discarded.
- REQ-026 ready SHALL return to 1 on the second edge after rstn returns high.

Configuration
- REQ-027 Macro SINGLE_PORT_RAM_ERROR_EN defined: error detection per REQ-020 and REQ-021 SHALL be active.
- REQ-028 Macro SINGLE_PORT_RAM_ERROR_EN undefined: error SHALL be tied to 0; invalid requests SHALL still be silently ignored (no memory or dout change).

Structure
- REQ-029 Package single_port_ram_pkg SHALL hold the default width and depth constants and the operation constants OP_WRITE=1 and OP_READ=0.
- REQ-030 The storage array with its clear, write and read ports SHALL be a sub-module spram_mem_array; request decoding, ready and error logic SHALL stay in single_port_ram.

Verification
- REQ-031 Single write/read:
  - Stimulus: write 0xDEADBEEF to addr 5, then read addr 5.
  - Response: dout=0xDEADBEEF one cycle after the read is accepted; error=0.
- REQ-032 Back-to-back:
  - Stimulus: write addr 0..31 with data = addr*0x01010101 on consecutive cycles, then read 0..31 on consecutive cycles.
  - Response: every read matches, with ready=1 throughout.
- REQ-033 Reset mid-write:
  - Stimulus: write 0x12345678 to addr 3 with rstn=0 in the same cycle, then read addr 3 after ready returns.
  - Response: dout=0; ready low for 2 cycles.
- REQ-034 Reset mid-read:
  - Stimulus: write 0xA5A5A5A5 to addr 7; issue a read of addr 7 with rstn=0.
  - Response: dout=0; a later read of addr 7 returns 0 because memory was cleared.
- REQ-035 Error handling:
  - Stimulus: valid=1, en=0, write 0xFFFFFFFF to addr 9.
  - Response: error=1 for exactly one cycle; a later read of addr 9 returns its prior value 0.
- REQ-036 Clock frequencies: the scenarios above SHALL pass at 100 MHz and at 250 MHz.
